// File: rtl/prefetch_unit_pkg.sv
// Shared defines for the instruction prefetch unit.
// Widths, reset PC, instruction size and FSM encodings.
package prefetch_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam int ILEN_BYTES = 4;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for fetched words and PC tags.
// Flush empties it on the next edge; head is read combinationally.
module fetch_fifo
  import prefetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers and occupancy; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Credit-based instruction prefetch unit with redirect drain.
// Optional same-cycle bypass when FETCH_BYPASS_EN is defined.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            redirect,
  input  logic [XLEN-1:0] npc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            validF,
  output logic [XLEN-1:0] pcF,
  output logic [XLEN-1:0] instrF
);

  localparam int CW = cnt_width(DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_next;
  logic [CW:0]     used;

  logic            in_fetch;
  logic            issue;
  logic            resp_ok;

  logic            iq_push;
  logic            iq_pop;
  logic            iq_full;
  logic            iq_empty;
  logic [CW-1:0]   iq_count;
  logic [2*XLEN-1:0] iq_rdata;

  logic            tq_pop;
  logic            tq_full;
  logic            tq_empty;
  logic [CW-1:0]   tq_count;
  logic [XLEN-1:0] tq_rdata;

  logic            unused_ok;

  assign in_fetch  = (state == FETCH);
  assign used      = {1'b0, iq_count} + {1'b0, outst};
  assign imem_req  = !rst && in_fetch && !redirect
                   && (used < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign resp_ok   = imem_rvalid && in_fetch && !redirect;
  assign tq_pop    = imem_rvalid && in_fetch;
  assign drop_next = outst - CW'(imem_rvalid);
  assign iq_pop    = !iq_empty && !stallF && !redirect;

`ifdef FETCH_BYPASS_EN
  logic byp;

  assign byp     = resp_ok && iq_empty;
  assign iq_push = resp_ok && !(byp && !stallF);
  assign validF  = !rst && (!iq_empty || byp);

  // Queue head wins; otherwise forward the arriving response.
  always_comb begin
    pcF    = '0;
    instrF = '0;
    if (validF && !iq_empty) begin
      pcF    = iq_rdata[2*XLEN-1:XLEN];
      instrF = iq_rdata[XLEN-1:0];
    end else if (validF) begin
      pcF    = tq_rdata;
      instrF = imem_rdata;
    end
  end
`else
  assign iq_push = resp_ok;
  assign validF  = !rst && !iq_empty;
  assign pcF     = validF ? iq_rdata[2*XLEN-1:XLEN] : '0;
  assign instrF  = validF ? iq_rdata[XLEN-1:0] : '0;
`endif

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_iq (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (iq_push),
    .wdata ({tq_rdata, imem_rdata}),
    .pop   (iq_pop),
    .rdata (iq_rdata),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_count)
  );

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tq (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (issue),
    .wdata (fetch_pc),
    .pop   (tq_pop),
    .rdata (tq_rdata),
    .full  (tq_full),
    .empty (tq_empty),
    .count (tq_count)
  );

  assign unused_ok = &{1'b0, iq_full, tq_full,
                       tq_empty, tq_count};

  // In-flight request count, tracked in both states.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst <= '0;
    end else begin
      outst <= outst + CW'(issue) - CW'(imem_rvalid);
    end
  end

  // FETCH/DRAIN control, fetch PC and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= npc;
      drop_cnt <= drop_next;
      state    <= (drop_next != '0) ? DRAIN : FETCH;
    end else begin
      unique case (1'b1)
        (state == FETCH): begin
          if (issue) begin
            fetch_pc <= fetch_pc + XLEN'(ILEN_BYTES);
          end
        end
        (state == DRAIN): begin
          if (imem_rvalid) begin
            drop_cnt <= drop_cnt - 1'b1;
            if (drop_cnt == CW'(1)) state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed self-checking bench for prefetch_unit.
// Memory model: always-grant, in-order, programmable latency.
module tb_prefetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int FL = 1;
`else
  localparam int FL = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        redirect;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        validF;
  logic [31:0] pcF;
  logic [31:0] instrF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int grants = 0;
  logic [31:0] pa[$];
  int          pd[$];

  prefetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stallF      (stallF),
    .redirect    (redirect),
    .npc         (npc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .validF      (validF),
    .pcF         (pcF),
    .instrF      (instrF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    if (rst) begin
      pa.delete();
      pd.delete();
    end else if (imem_req && imem_gnt) begin
      pa.push_back(imem_addr);
      pd.push_back(cyc + lat);
      grants++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst && pa.size() > 0 && pd[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~pa[0];
      void'(pa.pop_front());
      void'(pd.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stallF   = 1'b0;
    redirect = 1'b0;
    npc      = '0;
    imem_gnt = 1'b1;
    tick();
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", validF, 0);
    chk("rst_pc", pcF, 0);
    chk("rst_instr", instrF, 0);
    rst = 1'b0;
    grants = 0;
    #1;
  endtask

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // streaming, latency 1
    lat = 1;
    do_reset();
    chk("s_req0", imem_req, 1);
    chk("s_addr0", imem_addr, 0);
    chk("s_valid0", validF, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("s_addr", imem_addr, 4 * k);
      if (k < FL) begin
        chk("s_valid_lo", validF, 0);
      end else begin
        chk("s_valid_hi", validF, 1);
        chk("s_pc", pcF, 4 * (k - FL));
        chk("s_instr", instrF, ~(4 * (k - FL)));
      end
    end

    // stall until credits run out, then release
    do_reset();
    stallF = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) tick();
    chk("st_grants", grants, 4);
    chk("st_req", imem_req, 0);
    chk("st_valid", validF, 1);
    chk("st_pc", pcF, 0);
    stallF = 1'b0;
    #1;
    chk("rl_pc0", pcF, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rl_valid", validF, 1);
      chk("rl_pc", pcF, 4 * k);
    end

    // redirect with two outstanding, latency 3
    lat = 3;
    do_reset();
    chk("rd_addr0", imem_addr, 0);
    tick();
    tick();
    redirect = 1'b1;
    npc      = 32'h100;
    #1;
    chk("rd_req_blk", imem_req, 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("dr_req0", imem_req, 0);
    chk("dr_addr", imem_addr, 32'h100);
    chk("dr_rvalid", imem_rvalid, 1);
    chk("dr_valid0", validF, 0);
    tick();
    chk("dr_req1", imem_req, 0);
    chk("dr_valid1", validF, 0);
    tick();
    chk("rd_req", imem_req, 1);
    chk("rd_addr", imem_addr, 32'h100);
    for (int k = 5; k < 7 + FL; k++) begin
      chk("rd_valid_lo", validF, 0);
      tick();
    end
    chk("rd_valid", validF, 1);
    chk("rd_pc", pcF, 32'h100);
    chk("rd_instr", instrF, ~32'h100);

    // redirect coincident with the only response
    lat = 1;
    do_reset();
    tick();
    chk("co_rvalid", imem_rvalid, 1);
    redirect = 1'b1;
    npc      = 32'h200;
    #1;
    chk("co_valid_rd", validF, 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("co_req", imem_req, 1);
    chk("co_addr", imem_addr, 32'h200);
    chk("co_valid0", validF, 0);
    for (int k = 0; k < FL; k++) tick();
    chk("co_valid", validF, 1);
    chk("co_pc", pcF, 32'h200);

    // reset with the queue full
    do_reset();
    stallF = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) tick();
    chk("fr_valid_pre", validF, 1);
    rst = 1'b1;
    tick();
    chk("fr_valid", validF, 0);
    chk("fr_req", imem_req, 0);
    rst    = 1'b0;
    stallF = 1'b0;
    #1;
    chk("fr_req_rel", imem_req, 1);
    chk("fr_addr_rel", imem_addr, 0);

    // address wrap at the top of memory
    do_reset();
    redirect = 1'b1;
    npc      = 32'hFFFF_FFFC;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    chk("wr_req", imem_req, 1);
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_addr1", imem_addr, 32'h0);
    for (int k = 0; k < FL - 1; k++) tick();
    chk("wr_pc0", pcF, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc1", pcF, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
